// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access size codes and memory map defaults for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [31:0] MEM_TOP_DEF = 32'h0002FFFC;
  localparam logic [31:0] ROM_END_DEF = 32'h0001FFFF;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/halfword lane extract with sign/zero extension for loads and lane merge for stores
module lsu_lane_align import lsu_pkg::*; (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  always_comb begin
    sh = size == SZ_BYTE ? {addr_lo, 3'b000} : {addr_lo[1], 4'b0000};
    lane = rdata >> sh;
    load_data = size == SZ_BYTE ? {{24{is_signed & lane[7]}}, lane[7:0]} :
                size == SZ_HALF ? {{16{is_signed & lane[15]}}, lane[15:0]} : rdata;
    mask = (size == SZ_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_data = size == SZ_WORD ? wdata : (rdata & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core request to word-aligned memory bridge with RMW sub-word stores; LSU_WORD_STORE_BYPASS_EN skips READ for word stores
module load_store_unit import lsu_pkg::*; #(
  parameter logic [31:0] MEM_TOP = MEM_TOP_DEF,
  parameter logic [31:0] ROM_END = ROM_END_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_done,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_w_en,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);
  state_t      state_q, state_d;
  logic        we_q, we_d, signed_q, signed_d;
  logic [1:0]  size_q, size_d, addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_done_q, resp_done_d, resp_fault_q, resp_fault_d, mem_w_en_q, mem_w_en_d;
  logic [31:0] resp_rdata_q, resp_rdata_d, mem_addr_q, mem_addr_d, mem_w_data_q, mem_w_data_d;
  logic        fault, bypass;
  logic [31:0] load_data, merge_data;

  lsu_lane_align u_align (
    .addr_lo   (addr_lo_q),
    .size      (size_q),
    .is_signed (signed_q),
    .rdata     (mem_r_data),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  assign fault = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                 req_size == 2'b11 || req_addr[31:2] > MEM_TOP[31:2] || (req_we && req_addr <= ROM_END);
`ifdef LSU_WORD_STORE_BYPASS_EN
  assign bypass = req_we && req_size == SZ_WORD;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d = we_q;
    size_d = size_q;
    signed_d = signed_q;
    addr_lo_d = addr_lo_q;
    wdata_d = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        size_d = req_size;
        signed_d = req_signed;
        addr_lo_d = req_addr[1:0];
        wdata_d = req_wdata;
        resp_fault_d = fault;
        resp_rdata_d = '0;
        state_d = fault ? RESP : bypass ? WRITE : READ;
        if (!fault) mem_addr_d = {req_addr[31:2], 2'b00};
        if (!fault && bypass) mem_w_data_d = req_wdata;
      end
      READ: begin
        state_d = we_q ? WRITE : RESP;
        if (we_q) mem_w_data_d = merge_data;
        else resp_rdata_d = load_data;
      end
      WRITE: state_d = RESP;
      default: state_d = IDLE;
    endcase
    resp_done_d = state_d == RESP;
    mem_w_en_d = state_d == WRITE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      size_q <= '0;
      signed_q <= 1'b0;
      addr_lo_q <= '0;
      wdata_q <= '0;
      resp_done_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q <= '0;
      mem_w_en_q <= 1'b0;
      mem_w_data_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      size_q <= size_d;
      signed_q <= signed_d;
      addr_lo_q <= addr_lo_d;
      wdata_q <= wdata_d;
      resp_done_q <= resp_done_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_w_en_q <= mem_w_en_d;
      mem_w_data_q <= mem_w_data_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign resp_done = resp_done_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_w_en = mem_w_en_q;
  assign mem_w_data = mem_w_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a falling-edge-commit memory model
module tb_load_store_unit;
  import lsu_pkg::*;
`ifdef LSU_WORD_STORE_BYPASS_EN
  localparam int WST_LAT = 2;
`else
  localparam int WST_LAT = 3;
`endif
  typedef struct {
    string name;
    logic we;
    logic [1:0] size;
    logic sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic fault;
    int lat;
  } txn_t;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_done, resp_fault, mem_w_en;
  logic [31:0] resp_rdata, mem_addr, mem_w_data, mem_r_data;
  logic [31:0] mem [65536];
  txn_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  assign mem_r_data = mem[mem_addr[17:2]];
  always @(negedge clk) if (mem_w_en) mem[mem_addr[17:2]] <= mem_w_data;

  function automatic txn_t mk(string n, logic we, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic f, int l);
    txn_t t;
    t.name = n; t.we = we; t.size = sz; t.sgn = sg; t.addr = a; t.wdata = wd;
    t.rdata = rd; t.fault = f; t.lat = l;
    return t;
  endfunction

  task automatic run_req(input txn_t t, output logic [31:0] rd, output logic f, output int lat,
                         output int wen, output logic [31:0] waddr);
    @(negedge clk);
    sb.push_back(t);
    req_valid = 1; req_we = t.we; req_size = t.size; req_signed = t.sgn;
    req_addr = t.addr; req_wdata = t.wdata;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    @(negedge clk);
    req_valid = 0;
    rd = 0; f = 0; lat = -1; wen = 0; waddr = 0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_w_en) begin wen++; waddr = mem_addr; end
      if (resp_done) begin lat = c; rd = resp_rdata; f = resp_fault; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    #1 rst = 0;
    #20;
    checks++;
    if (req_ready !== 1'b1 || {resp_done, resp_fault, mem_w_en} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl ready=%b done/fault/wen=%b want 1/000", req_ready, {resp_done, resp_fault, mem_w_en});
    end
    checks++;
    if ({mem_addr, mem_w_data, resp_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_w_data, resp_rdata);
    end
    @(negedge clk) rst = 1;
  endtask

  task automatic test_word();
    logic [31:0] rd, wa; logic f; int lat, wen; txn_t e;
    run_req(mk("wst", 1, SZ_WORD, 0, 32'h0002_0010, 32'hDEAD_BEEF, 0, 0, WST_LAT), rd, f, lat, wen, wa);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || f !== e.fault) begin errors++; $display("FAIL %s lat=%0d fault=%b want %0d/%b", e.name, lat, f, e.lat, e.fault); end
    checks++;
    if (wen !== 1 || wa !== 32'h0002_0010) begin errors++; $display("FAIL wst_wen count=%0d addr=%h want 1/00020010", wen, wa); end
    checks++;
    if (mem[32'h0002_0010 >> 2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wst_mem got %h want deadbeef", mem[32'h0002_0010 >> 2]); end
    run_req(mk("wld", 0, SZ_WORD, 1, 32'h0002_0010, 0, 32'hDEAD_BEEF, 0, 2), rd, f, lat, wen, wa);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || f !== e.fault || lat !== e.lat) begin
      errors++; $display("FAIL %s rdata=%h fault=%b lat=%0d want %h/%b/%0d", e.name, rd, f, lat, e.rdata, e.fault, e.lat);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd, wa; logic f; int lat, wen; txn_t e;
    mem[32'h0002_0020 >> 2] = 32'h1122_3344;
    run_req(mk("bst", 1, SZ_BYTE, 0, 32'h0002_0022, 32'h5566_77AA, 0, 0, 3), rd, f, lat, wen, wa);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || f !== e.fault || wen !== 1) begin errors++; $display("FAIL %s lat=%0d fault=%b wen=%0d want %0d/%b/1", e.name, lat, f, wen, e.lat, e.fault); end
    checks++;
    if (mem[32'h0002_0020 >> 2] !== 32'h11AA_3344) begin errors++; $display("FAIL bst_mem got %h want 11aa3344", mem[32'h0002_0020 >> 2]); end
    run_req(mk("sbld", 0, SZ_BYTE, 1, 32'h0002_0022, 0, 32'hFFFF_FFAA, 0, 2), rd, f, lat, wen, wa);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || f !== e.fault || lat !== e.lat) begin
      errors++; $display("FAIL %s rdata=%h fault=%b lat=%0d want %h/%b/%0d", e.name, rd, f, lat, e.rdata, e.fault, e.lat);
    end
  endtask

  task automatic test_half_loads();
    logic [31:0] rd, wa; logic f; int lat, wen; txn_t e; txn_t ts[$];
    mem[32'h0002_0020 >> 2] = 32'h8001_7FFE;
    ts.push_back(mk("uhld_hi", 0, SZ_HALF, 0, 32'h0002_0022, 0, 32'h0000_8001, 0, 2));
    ts.push_back(mk("shld_hi", 0, SZ_HALF, 1, 32'h0002_0022, 0, 32'hFFFF_8001, 0, 2));
    ts.push_back(mk("shld_lo", 0, SZ_HALF, 1, 32'h0002_0020, 0, 32'h0000_7FFE, 0, 2));
    ts.push_back(mk("ubld_b3", 0, SZ_BYTE, 0, 32'h0002_0023, 0, 32'h0000_0080, 0, 2));
    foreach (ts[i]) begin
      run_req(ts[i], rd, f, lat, wen, wa);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || f !== e.fault || lat !== e.lat || wen !== 0) begin
        errors++; $display("FAIL %s rdata=%h fault=%b lat=%0d wen=%0d want %h/%b/%0d/0", e.name, rd, f, lat, wen, e.rdata, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd, wa; logic f; int lat, wen; txn_t e; txn_t ts[$];
    mem[32'h0002_FFFC >> 2] = 32'hCAFE_F00D;
    ts.push_back(mk("f_word_mis", 0, SZ_WORD, 0, 32'h0002_0011, 0, 0, 1, 1));
    ts.push_back(mk("f_half_mis", 0, SZ_HALF, 0, 32'h0002_0021, 0, 0, 1, 1));
    ts.push_back(mk("f_rom_st", 1, SZ_WORD, 0, 32'h0000_0100, 32'h1, 0, 1, 1));
    ts.push_back(mk("f_rom_end", 1, SZ_BYTE, 0, 32'h0001_FFFF, 32'h1, 0, 1, 1));
    ts.push_back(mk("f_range", 0, SZ_WORD, 0, 32'h0003_0000, 0, 0, 1, 1));
    ts.push_back(mk("f_size11", 0, 2'b11, 0, 32'h0002_0010, 0, 0, 1, 1));
    ts.push_back(mk("ok_top", 0, SZ_WORD, 0, 32'h0002_FFFC, 0, 32'hCAFE_F00D, 0, 2));
    ts.push_back(mk("ok_rom_ld", 0, SZ_BYTE, 0, 32'h0000_0100, 0, 32'h0000_0000, 0, 2));
    ts.push_back(mk("ok_ram_st", 1, SZ_WORD, 0, 32'h0002_0000, 32'h0BAD_F00D, 0, 0, WST_LAT));
    mem[32'h0000_0100 >> 2] = 32'h0000_0000;
    foreach (ts[i]) begin
      run_req(ts[i], rd, f, lat, wen, wa);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || f !== e.fault || lat !== e.lat || wen !== ((e.we && !e.fault) ? 1 : 0)) begin
        errors++; $display("FAIL %s rdata=%h fault=%b lat=%0d wen=%0d want %h/%b/%0d", e.name, rd, f, lat, wen, e.rdata, e.fault, e.lat);
      end
    end
    checks++;
    if (mem[32'h0002_0000 >> 2] !== 32'h0BAD_F00D) begin errors++; $display("FAIL ok_ram_st_mem got %h want 0badf00d", mem[32'h0002_0000 >> 2]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wa; logic f; int lat, wen; txn_t e; txn_t ts[$];
    mem[32'h0002_0040 >> 2] = 32'h0000_0000;
    ts.push_back(mk("b2b_bst", 1, SZ_BYTE, 0, 32'h0002_0040, 32'hFFFF_FF11, 0, 0, 3));
    ts.push_back(mk("b2b_hst", 1, SZ_HALF, 0, 32'h0002_0042, 32'h1234_BEEF, 0, 0, 3));
    ts.push_back(mk("b2b_wld", 0, SZ_WORD, 0, 32'h0002_0040, 0, 32'hBEEF_0011, 0, 2));
    ts.push_back(mk("b2b_shld", 0, SZ_HALF, 1, 32'h0002_0042, 0, 32'hFFFF_BEEF, 0, 2));
    ts.push_back(mk("b2b_ubld", 0, SZ_BYTE, 0, 32'h0002_0043, 0, 32'h0000_00BE, 0, 2));
    ts.push_back(mk("b2b_sbld", 0, SZ_BYTE, 1, 32'h0002_0041, 0, 32'h0000_0000, 0, 2));
    foreach (ts[i]) begin
      run_req(ts[i], rd, f, lat, wen, wa);
      e = sb.pop_front();
      checks++;
      if ((!e.we && rd !== e.rdata) || f !== e.fault || lat !== e.lat) begin
        errors++; $display("FAIL %s rdata=%h fault=%b lat=%0d want %h/%b/%0d", e.name, rd, f, lat, e.rdata, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic seen = 0, done_seen = 0;
    logic [31:0] rd, wa; logic f; int lat, wen; txn_t e;
    mem[32'h0002_0030 >> 2] = 32'h5555_5555;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = SZ_WORD; req_signed = 0;
    req_addr = 32'h0002_0030; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_w_en) begin seen = 1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL mid_rst_write_seen got %b want 1", seen); end
    rst = 0;
    #1;
    checks++;
    if (mem_w_en !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_rst_async wen=%b ready=%b addr=%h want 0/1/0", mem_w_en, req_ready, mem_addr);
    end
    @(negedge clk) rst = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_done) done_seen = 1;
    end
    checks++;
    if (done_seen !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_no_done done=%b ready=%b want 0/1", done_seen, req_ready); end
    checks++;
    if (mem[32'h0002_0030 >> 2] !== 32'h5555_5555) begin errors++; $display("FAIL mid_rst_mem got %h want 55555555", mem[32'h0002_0030 >> 2]); end
    run_req(mk("post_rst_ld", 0, SZ_WORD, 0, 32'h0002_0010, 0, 32'hDEAD_BEEF, 0, 2), rd, f, lat, wen, wa);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || f !== e.fault || lat !== e.lat) begin
      errors++; $display("FAIL %s rdata=%h fault=%b lat=%0d want %h/%b/%0d", e.name, rd, f, lat, e.rdata, e.fault, e.lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_loads();
    test_faults();
    test_back_to_back();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
